// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence display block: FSM encodings and
// default display timings also used by the control unit.
package exibe_sequencia_pkg;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LE_MEM  = 3'd1;
  localparam logic [2:0] CAPTURA = 3'd2;
  localparam logic [2:0] MOSTRA  = 3'd3;
  localparam logic [2:0] APAGA   = 3'd4;
  localparam logic [2:0] FIM     = 3'd5;

  localparam int T_ON_PADRAO  = 1000;
  localparam int T_OFF_PADRAO = 500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; clear has priority over count.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clock) begin
    if (zera_s) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == N'(M - 1)) ? '0 : r_q + 1'b1;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/exibe_sequencia.sv
// Reads tamanho items from the game ROM and shows each on the LEDs for T_ON
// cycles followed by a T_OFF blank gap, then pulses pronto.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON  = T_ON_PADRAO,
  parameter int T_OFF = T_OFF_PADRAO,
  parameter int W_T   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] tamanho,
  input  logic [3:0] dado_rom,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam int M_T = max_int(T_ON, T_OFF);
  localparam logic [W_T-1:0] FIM_ON  = W_T'(T_ON - 1);
  localparam logic [W_T-1:0] FIM_OFF = W_T'(T_OFF - 1);

  logic [2:0]     r_estado;
  logic [2:0]     w_estado_prox;
  logic [3:0]     r_tamanho;
  logic [3:0]     r_indice;
  logic [3:0]     r_endereco;
  logic [3:0]     r_leds;
  logic           r_ocupado;
  logic           r_pronto;
  logic [W_T-1:0] w_timer;
  logic           w_zera;
  logic           w_conta;
  logic           w_fim_tempo;
  logic           w_ultimo;

  // Timer is held cleared outside MOSTRA/APAGA and on every phase change.
  contador_m #(
    .M (M_T),
    .N (W_T)
  ) u_timer (
    .clock  (clock),
    .zera_s (reset | w_zera),
    .conta  (w_conta),
    .Q      (w_timer)
  );

  assign w_ultimo = (r_indice == r_tamanho - 4'd1);

  always_comb begin
    w_estado_prox = r_estado;
    w_zera        = 1'b1;
    w_conta       = 1'b0;
    w_fim_tempo   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
          w_estado_prox = (tamanho == 4'd0) ? FIM : LE_MEM;
        end
      end
      LE_MEM:  w_estado_prox = CAPTURA;
      CAPTURA: w_estado_prox = MOSTRA;
      MOSTRA: begin
        w_conta     = 1'b1;
        w_fim_tempo = (w_timer == FIM_ON);
        w_zera      = w_fim_tempo;
        if (w_fim_tempo) begin
          w_estado_prox = APAGA;
        end
      end
      APAGA: begin
        w_conta     = 1'b1;
        w_fim_tempo = (w_timer == FIM_OFF);
        w_zera      = w_fim_tempo;
        if (w_fim_tempo) begin
          w_estado_prox = w_ultimo ? FIM : LE_MEM;
        end
      end
      FIM:     w_estado_prox = OCIOSO;
      default: w_estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_tamanho  <= 4'd0;
      r_indice   <= 4'd0;
      r_endereco <= 4'd0;
      r_leds     <= 4'd0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_ocupado <= (w_estado_prox != OCIOSO);
      r_pronto  <= (w_estado_prox == FIM);

      // LED register mirrors the state that is about to be entered.
      if (w_estado_prox != MOSTRA) begin
        r_leds <= 4'd0;
      end else if (r_estado == CAPTURA) begin
        r_leds <= dado_rom;
      end

      if (r_estado == OCIOSO && iniciar) begin
        r_tamanho  <= tamanho;
        r_indice   <= 4'd0;
        r_endereco <= 4'd0;
      end else if (r_estado == APAGA && w_fim_tempo && !w_ultimo) begin
        r_indice   <= r_indice + 4'd1;
        r_endereco <= r_endereco + 4'd1;
      end
    end
  end

  assign endereco  = r_endereco;
  assign leds      = r_leds;
  assign ocupado   = r_ocupado;
  assign pronto    = r_pronto;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed and randomized checks of exibe_sequencia against a per-cycle trace
// built from the item/timing rules.
module tb_exibe_sequencia;

  localparam int T_ON  = 3;
  localparam int T_OFF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] tamanho;
  logic [3:0] dado_rom;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] rom [16];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lv;
    logic [3:0] ad;
    logic       pr;
  } passo_t;

  passo_t fila[$];

  always #5 clk = ~clk;

  always @(posedge clk) dado_rom <= rom[endereco];

  exibe_sequencia #(
    .T_ON  (T_ON),
    .T_OFF (T_OFF),
    .W_T   (16)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .iniciar   (iniciar),
    .tamanho   (tamanho),
    .dado_rom  (dado_rom),
    .endereco  (endereco),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_estado"}, db_estado, 8'd0);
    chk({tag, "_leds"}, leds, 8'd0);
    chk({tag, "_ocupado"}, ocupado, 8'd0);
    chk({tag, "_pronto"}, pronto, 8'd0);
  endtask

  function automatic passo_t mk(input int st, input int lv, input int ad, input int pr);
    passo_t p;
    p.st = 3'(st);
    p.lv = 4'(lv);
    p.ad = 4'(ad);
    p.pr = 1'(pr);
    return p;
  endfunction

  // Expected per-cycle trace starting at the cycle after acceptance.
  task automatic build_trace(input int n);
    fila.delete();
    for (int i = 0; i < n; i++) begin
      fila.push_back(mk(1, 0, i, 0));
      fila.push_back(mk(2, 0, i, 0));
      for (int t = 0; t < T_ON; t++)  fila.push_back(mk(3, int'(rom[i]), i, 0));
      for (int t = 0; t < T_OFF; t++) fila.push_back(mk(4, 0, i, 0));
    end
    fila.push_back(mk(5, 0, 0, 1));
  endtask

  task automatic run_seq(input int n, input bit keep, input int glitch_at, input int abort_at);
    passo_t p;
    iniciar = 1'b1;
    tamanho = 4'(n);
    tick();
    tamanho = 4'($urandom_range(0, 15));
    build_trace(n);
    if (fila.size() != n * (2 + T_ON + T_OFF) + 1) $fatal(1, "trace builder broken");
    $display("seq n=%0d keep=%0d glitch=%0d abort=%0d cycles=%0d", n, keep, glitch_at, abort_at, fila.size());
    for (int k = 0; k < fila.size(); k++) begin
      p = fila[k];
      chk("estado", db_estado, p.st);
      chk("leds", leds, p.lv);
      chk("pronto", pronto, p.pr);
      chk("ocupado", ocupado, 8'd1);
      if (p.st != 3'd5) chk("endereco", endereco, p.ad);
      iniciar = keep || (k == glitch_at);
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("pos_reset");
        chk("pos_reset_endereco", endereco, 8'd0);
        return;
      end
      tick();
    end
    chk_idle("ocioso");
  endtask

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    tamanho = 4'd0;
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    tick();
    tick();
    reset = 1'b0;
    chk_idle("reset");
    chk("reset_endereco", endereco, 8'd0);
    tick();

    // Basic three-item sequence
    rom[0] = 4'd1; rom[1] = 4'd8; rom[2] = 4'd4;
    run_seq(3, 1'b0, -1, -1);
    iniciar = 1'b0;
    tick();

    // Empty sequence
    run_seq(0, 1'b0, -1, -1);
    iniciar = 1'b0;
    tick();

    // Restart request during MOSTRA of item 1 is ignored
    run_seq(3, 1'b0, 2 + T_ON + T_OFF + 2, -1);
    iniciar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("sem_reinicio");
    end

    // Reset during APAGA of item 0, then replay from address 0
    run_seq(3, 1'b0, -1, 2 + T_ON);
    iniciar = 1'b0;
    tick();
    chk_idle("pos_abort");
    run_seq(3, 1'b0, -1, -1);
    iniciar = 1'b0;
    tick();

    // Full-length sequence; address 15 holds a distinct value
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    run_seq(15, 1'b0, -1, -1);
    iniciar = 1'b0;
    tick();

    // Held start: back-to-back single-item sequences
    rom[0] = 4'd9;
    for (int r = 0; r < 3; r++) run_seq(1, 1'b1, -1, -1);
    iniciar = 1'b0;
    tick();
    chk_idle("fim_mantido");

    // Randomized contents and lengths
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
      run_seq(int'($urandom_range(0, 15)), 1'b0, -1, -1);
      iniciar = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
Transmit side of the MindFocus play interface. The datapath receives and checks the player's button presses; this block presents the target sequence to the player. On a start pulse it reads `tamanho` items from the game ROM (addresses 0..tamanho-1) and shows each item on the 4 LEDs for T_ON cycles, followed by a T_OFF-cycle blank gap. It signals completion with a one-cycle `pronto` pulse, which tells the control unit it may open the play window.

Parameters:
- T_ON, default 1000, number of cycles an item stays lit (≥1).
- T_OFF, default 500, number of cycles of blank gap after each item (≥1).
- W_T, default 16, width of the timer counter; must hold max(T_ON, T_OFF).

Ports:
- clock, in, 1: system clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- iniciar, in, 1: start request; sampled only in OCIOSO.
- tamanho, in, 4: number of items to show (0..15); latched when start is accepted.
- dado_rom, in, 4: ROM data_out. The ROM is synchronous with 1-cycle latency.
- endereco, out, 4: ROM address (registered).
- leds, out, 4: LED drive; shows the item value while lit, 0 otherwise.
- ocupado, out, 1: high in every state except OCIOSO.
- pronto, out, 1: one-cycle pulse at the end of the sequence.
- db_estado, out, 3: current state encoding, for debug.

Behaviour:
- Interface: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values (taking effect on the edge after reset is sampled high; this applies mid-sequence too, aborting with no pronto):
  - state = OCIOSO
  - endereco = 0, leds = 0, ocupado = 0, pronto = 0
  - item index = 0, timer = 0
- States:
  - OCIOSO (0)
  - LE_MEM (1)
  - CAPTURA (2)
  - MOSTRA (3)
  - APAGA (4)
  - FIM (5)
  - Encodings 6 and 7 are illegal and go to OCIOSO.
- OCIOSO:
  - leds = 0.
  - If iniciar = 1: latch tamanho and set index = 0.
  - Then go to FIM if tamanho = 0, else go to LE_MEM with endereco = 0.
- LE_MEM (1 cycle): endereco = index is stable. The ROM registers it at the end of this cycle.
- CAPTURA (1 cycle): dado_rom is valid. Latch it into the LED register; load timer = 0.
- MOSTRA:
  - leds = latched item.
  - The timer increments each cycle; after exactly T_ON cycles go to APAGA with the timer cleared.
- APAGA:
  - leds = 0.
  - After exactly T_OFF cycles:
    - if index = tamanho_latched-1, go to FIM;
    - else index+1 and endereco+1, then go to LE_MEM.
- FIM (1 cycle): pronto = 1, ocupado = 1, leds = 0; then go to OCIOSO.
- Latency and timing:
  - Each item takes 2+T_ON+T_OFF cycles.
  - The first LE_MEM cycle is the cycle after iniciar is sampled.
  - FIM occurs tamanho*(2+T_ON+T_OFF) cycles after the first LE_MEM cycle begins.
  - With tamanho = 0, FIM is the cycle immediately after acceptance.
- iniciar while ocupado: ignored; no restart and no queuing. A held iniciar re-triggers only once the block is back in OCIOSO.
- A change to tamanho after acceptance has no effect.
- Item value 0: LEDs remain dark for T_ON cycles, but the item is still counted and still timed.
- Index range: tamanho = 15 gives addresses 0..14. The index never wraps.
- leds and pronto are registered outputs, so there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header:
  - state encodings (OCIOSO..FIM, 3 bits);
  - default T_ON/T_OFF constants shared with the control unit.
- One sub-module: reuse contador_m as the MOSTRA/APAGA timer.
  - zera_s is driven by the FSM.
  - M = max(T_ON, T_OFF).
  - The terminal count is compared against T_ON or T_OFF as selected by the state.
- The FSM and the index register stay in this module.

Test Plan:
1. T_ON=3, T_OFF=2, ROM[0..2]=1,8,4, tamanho=3, iniciar pulse.
   - leds = 1 for 3 cycles, 0 for 4 cycles, 8 for 3 cycles, 0 for 4 cycles, 4 for 3 cycles, 0 for 2 cycles.
   - pronto occurs exactly 21 cycles after the first LE_MEM cycle; endereco steps 0, 1, 2.
2. tamanho=0, iniciar pulse.
   - leds stay 0 throughout.
   - pronto is high in the 2nd cycle after iniciar is sampled; ocupado is high for that 1 cycle only.
3. Second iniciar pulse during MOSTRA of item 1 in scenario 1.
   - Output trace is identical to scenario 1.
   - Exactly one pronto pulse.
4. reset asserted during APAGA of item 0.
   - Next cycle: leds = 0, endereco = 0, ocupado = 0, db_estado = 0; no pronto pulse.
   - A new iniciar replays the sequence from address 0.
5. tamanho=15, ROM = 0..14, T_ON=T_OFF=1.
   - endereco reaches 14 and never reaches 15.
   - 15 items shown; pronto occurs 60 cycles after the first LE_MEM cycle.
6. iniciar held high continuously, tamanho=1.
   - Sequences repeat back to back.
   - Exactly one OCIOSO cycle between each FIM and the next LE_MEM.
